// File: rtl/p1_motion_ctrl_pkg.sv
// rtl/p1_motion_ctrl_pkg.sv - screen/sprite constants and motion state encoding
package p1_motion_ctrl_pkg;

  localparam int SCREEN_H         = 480;
  localparam int SPRITE_H         = 50;
  localparam int SPRITE_W         = 30;
  localparam int SPRITE_X         = 500;
  localparam int SPRITE_ROM_DEPTH = SPRITE_W * SPRITE_H;
  localparam int COORD_W          = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } p1_state_e;

endpackage

// File: rtl/p1_speed_ramp.sv
// rtl/p1_speed_ramp.sv - per-frame speed ramp: STEP on restart, +STEP every ACCEL_FRAMES ticks
module p1_speed_ramp
  import p1_motion_ctrl_pkg::*;
#(
  parameter int STEP         = 2,
  parameter int MAX_SPEED    = 8,
  parameter int ACCEL_FRAMES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_i,
  input  logic               same_dir_i,
  input  logic               restart_i,
  output logic [COORD_W-1:0] speed_o
);

  localparam int                  ACC_W    = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [ACC_W-1:0]    ACC_LAST = ACC_W'(ACCEL_FRAMES - 1);
  localparam logic [COORD_W-1:0]  STEP_C   = COORD_W'(STEP);
  localparam logic [COORD_W-1:0]  MAX_C    = COORD_W'(MAX_SPEED);

  logic [ACC_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [COORD_W-1:0] speed_q, speed_d, speed_inc;

  assign speed_inc = speed_q + STEP_C;

  // The entry tick counts as the first frame of a run, so the speed steps
  // up on the ACCEL_FRAMES-th consecutive tick and every ACCEL_FRAMES after.
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    speed_d   = speed_q;
    if (restart_i) begin
      acc_cnt_d = '0;
      speed_d   = STEP_C;
    end else if (same_dir_i) begin
      acc_cnt_d = (acc_cnt_q == ACC_LAST) ? '0 : acc_cnt_q + 1'b1;
      if (acc_cnt_d == ACC_LAST) begin
        speed_d = (speed_inc > MAX_C) ? MAX_C : speed_inc;
      end
    end else begin
      acc_cnt_d = '0;
      speed_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_q <= '0;
      speed_q   <= '0;
    end else if (tick_i) begin
      acc_cnt_q <= acc_cnt_d;
      speed_q   <= speed_d;
    end
  end

  assign speed_o = speed_d;

endmodule

// File: rtl/p1_motion_ctrl.sv
// rtl/p1_motion_ctrl.sv - player-1 vertical position: frame-paced, accelerated, clamped
module p1_motion_ctrl
  import p1_motion_ctrl_pkg::*;
#(
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = SCREEN_H - SPRITE_H,
  parameter int Y_INIT       = 215,
  parameter int STEP         = 2,
  parameter int MAX_SPEED    = 8,
  parameter int ACCEL_FRAMES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               freeze,
  output logic [COORD_W-1:0] P1_y,
  output logic               moving,
  output logic               at_limit
);

  localparam int                       YW            = COORD_W + 1;
  localparam logic signed [COORD_W:0]  Y_MIN_S       = YW'(Y_MIN);
  localparam logic signed [COORD_W:0]  Y_MAX_S       = YW'(Y_MAX);
  localparam logic [COORD_W-1:0]       Y_INIT_C      = COORD_W'(Y_INIT);
  localparam logic                     AT_LIMIT_INIT = (Y_INIT == Y_MIN) || (Y_INIT == Y_MAX);

  p1_state_e          state_q, state_d, dir;
  logic [COORD_W-1:0] y_q, y_d;
  logic               moving_q, moving_d;
  logic               at_limit_q, at_limit_d;
  logic               same_dir, restart;
  logic [COORD_W-1:0] speed;
  logic signed [COORD_W:0] y_ext, spd_ext, y_calc;

  always_comb begin
    dir = ST_IDLE;
    if (!freeze) begin
      if (btn_up && !btn_down) begin
        dir = ST_UP;
      end else if (btn_down && !btn_up) begin
        dir = ST_DOWN;
      end
    end
  end

  assign same_dir = (dir != ST_IDLE) && (dir == state_q);
  assign restart  = (dir != ST_IDLE) && (dir != state_q);

  p1_speed_ramp #(
    .STEP         (STEP),
    .MAX_SPEED    (MAX_SPEED),
    .ACCEL_FRAMES (ACCEL_FRAMES)
  ) u_speed_ramp (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (frame_tick),
    .same_dir_i (same_dir),
    .restart_i  (restart),
    .speed_o    (speed)
  );

  // One extra bit of headroom keeps y - speed from wrapping before the clamp.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    moving_d   = moving_q;
    at_limit_d = at_limit_q;
    y_ext      = {1'b0, y_q};
    spd_ext    = {1'b0, speed};
    y_calc     = y_ext;
    if (frame_tick) begin
      state_d = dir;
      unique case (dir)
        ST_UP: begin
          y_calc = y_ext - spd_ext;
          if (y_calc < Y_MIN_S) y_calc = Y_MIN_S;
        end
        ST_DOWN: begin
          y_calc = y_ext + spd_ext;
          if (y_calc > Y_MAX_S) y_calc = Y_MAX_S;
        end
        default: ;
      endcase
      y_d        = y_calc[COORD_W-1:0];
      moving_d   = (dir != ST_IDLE);
      at_limit_d = (y_calc == Y_MIN_S) || (y_calc == Y_MAX_S);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      y_q        <= Y_INIT_C;
      moving_q   <= 1'b0;
      at_limit_q <= AT_LIMIT_INIT;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      moving_q   <= moving_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign P1_y     = y_q;
  assign moving   = moving_q;
  assign at_limit = at_limit_q;

endmodule

// File: tb/tb_p1_motion_ctrl.sv
// tb/tb_p1_motion_ctrl.sv - self-checking bench for p1_motion_ctrl
module tb_p1_motion_ctrl;

  localparam int Y_MIN  = 0;
  localparam int Y_MAX  = 430;
  localparam int Y_INIT = 215;
  localparam int STEP   = 2;
  localparam int MAXSPD = 8;
  localparam int ACCEL  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, btn_up, btn_down, freeze;
  logic [10:0] P1_y;
  logic        moving, at_limit;

  int total = 0;
  int bad   = 0;

  // Reference model: run length of the current direction determines speed.
  int m_y, m_dir, m_run;
  bit m_mov, m_lim;

  typedef struct {
    bit tick, up, dn, frz;
    int exp_y;
    bit exp_mov, exp_lim;
  } vec_t;
  vec_t vecs[$];

  p1_motion_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .freeze     (freeze),
    .P1_y       (P1_y),
    .moving     (moving),
    .at_limit   (at_limit)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_y = Y_INIT; m_dir = 0; m_run = 0; m_mov = 0; m_lim = 0;
  endfunction

  function automatic void model_tick(bit up, bit dn, bit frz);
    int dir;
    int spd;
    dir = frz ? 0 : (up && !dn) ? 1 : (dn && !up) ? 2 : 0;
    if (dir == 0)          m_run = 0;
    else if (dir == m_dir) m_run = m_run + 1;
    else                   m_run = 1;
    m_dir = dir;
    spd = STEP * (1 + m_run / ACCEL);
    if (spd > MAXSPD) spd = MAXSPD;
    if (dir == 1)      m_y = (m_y - spd < Y_MIN) ? Y_MIN : m_y - spd;
    else if (dir == 2) m_y = (m_y + spd > Y_MAX) ? Y_MAX : m_y + spd;
    m_mov = (dir != 0);
    m_lim = (m_y == Y_MIN) || (m_y == Y_MAX);
  endfunction

  // Called at a negedge; applies inputs for one clock and returns at the next negedge.
  task automatic do_cycle(input bit tick, input bit up, input bit dn, input bit frz, input bit chk);
    frame_tick = tick; btn_up = up; btn_down = dn; freeze = frz;
    @(posedge clk);
    if (tick) model_tick(up, dn, frz);
    @(negedge clk);
    if (chk) begin
      check("model_y", int'(P1_y), m_y);
      check("model_moving", int'(moving), int'(m_mov));
      check("model_at_limit", int'(at_limit), int'(m_lim));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    frame_tick = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_y", int'(P1_y), Y_INIT);
    check("async_rst_moving", int'(moving), 0);
    check("async_rst_at_limit", int'(at_limit), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int d;
    rst = 1'b1; frame_tick = 0; btn_up = 0; btn_down = 0; freeze = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_y", int'(P1_y), Y_INIT);
    check("reset_moving", int'(moving), 0);
    check("reset_at_limit", int'(at_limit), 0);
    rst = 1'b0;

    // tick up dn frz  y   mov lim
    vecs.push_back('{1, 1, 0, 0, 213, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 211, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 209, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 205, 1, 0});
    vecs.push_back('{1, 1, 1, 0, 205, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 205, 0, 0});
    vecs.push_back('{1, 1, 0, 1, 205, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 205, 0, 0});
    vecs.push_back('{1, 1, 0, 0, 203, 1, 0});
    vecs.push_back('{1, 0, 1, 0, 205, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 205, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 205, 0, 0});
    for (int i = 0; i < vecs.size(); i++) begin
      do_cycle(vecs[i].tick, vecs[i].up, vecs[i].dn, vecs[i].frz, 1'b0);
      check($sformatf("tbl_y[%0d]", i), int'(P1_y), vecs[i].exp_y);
      check($sformatf("tbl_moving[%0d]", i), int'(moving), int'(vecs[i].exp_mov));
      check($sformatf("tbl_at_limit[%0d]", i), int'(at_limit), int'(vecs[i].exp_lim));
    end

    // Accelerate down to full speed, then reverse: first reversed step is STEP.
    do_reset();
    for (int i = 0; i < 12; i++) do_cycle(1, 0, 1, 0, 1);
    check("accel_down_y", int'(P1_y), 269);
    do_cycle(1, 1, 0, 0, 1);
    check("reverse_y", int'(P1_y), 267);

    // Clamp at the bottom, then at the top.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      do_cycle(1, 0, 1, 0, 1);
      check("bottom_range", int'(P1_y <= 11'(Y_MAX)), 1);
    end
    check("bottom_y", int'(P1_y), Y_MAX);
    check("bottom_at_limit", int'(at_limit), 1);
    for (int i = 0; i < 60; i++) begin
      do_cycle(1, 1, 0, 0, 1);
      check("top_range", int'(P1_y <= 11'(Y_MAX)), 1);
    end
    check("top_y", int'(P1_y), Y_MIN);
    check("top_at_limit", int'(at_limit), 1);
    check("top_moving", int'(moving), 1);

    // No frame tick: nothing moves.
    for (int i = 0; i < 1000; i++) do_cycle(0, 1, 0, 0, 0);
    check("notick_y", int'(P1_y), Y_MIN);
    check("notick_moving", int'(moving), 1);
    check("notick_at_limit", int'(at_limit), 1);

    // Randomized runs against the model, with an asynchronous reset mid-way.
    do_reset();
    d = 2;
    for (int i = 0; i < 400; i++) begin
      bit tk, up, dn, fz;
      if (i == 200) do_reset();
      if ($urandom_range(7) == 0) d = $urandom_range(3);
      tk = ($urandom_range(1) == 1);
      fz = ($urandom_range(15) == 0);
      up = (d == 1) || (d == 3);
      dn = (d == 2) || (d == 3);
      do_cycle(tk, up, dn, fz, 1);
    end

    frame_tick = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p1_motion_ctrl.md
Name: p1_motion_ctrl

Overview:
- Owns the player-1 sprite vertical position, `P1_y`, which the player-1 pixel address generator consumes.
- Converts up/down button levels into accelerated, clamped motion.
- Updates only on the once-per-frame tick so the sprite never tears mid-scan.
- Sits between the input conditioning logic and the VGA sprite address path.

Parameters:
- Y_MIN, 0: topmost legal P1_y.
- Y_MAX, 430: bottommost legal P1_y (480 lines minus 50-line sprite).
- Y_INIT, 215: P1_y after reset.
- STEP, 2: initial speed and speed increment, in lines per frame.
- MAX_SPEED, 8: speed ceiling, in lines per frame.
- ACCEL_FRAMES, 4: consecutive same-direction ticks per speed increment.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse at start of vertical blanking.
- btn_up  in  1  debounced level, move up.
- btn_down  in  1  debounced level, move down.
- freeze  in  1  game-paused level; suppresses motion.
- P1_y  out  11  registered sprite top line, feeds the address generator.
- moving  out  1  registered; 1 when state is not IDLE.
- at_limit  out  1  registered; 1 when P1_y equals Y_MIN or Y_MAX.

Behaviour:
- Reset (async, active-high, one clock `clk`):
  - P1_y=Y_INIT, state=IDLE, speed=0, acc_cnt=0, moving=0.
  - at_limit=(Y_INIT==Y_MIN or Y_INIT==Y_MAX).
  - Reset takes effect immediately, including mid-frame or mid-move.
- Registers change only on a clk edge where frame_tick=1; all other cycles hold. New values are visible the cycle after the tick (latency 1).
- Direction decode, sampled on the tick:
  - up only -> UP; down only -> DOWN.
  - both, or neither -> NONE.
  - freeze=1 forces NONE.
- State machine, states IDLE/UP/DOWN, evaluated per tick:
  - dir NONE -> IDLE, speed=0, acc_cnt=0, P1_y holds.
  - dir differs from current state (entry from IDLE or reversal) -> new state, speed=STEP, acc_cnt=0.
  - dir equals current state:
    - if acc_cnt==ACCEL_FRAMES-1: acc_cnt=0, speed=min(speed+STEP, MAX_SPEED).
    - otherwise acc_cnt+1.
- Position uses the speed computed on this same tick:
  - UP: P1_y=max(Y_MIN, P1_y-speed).
  - DOWN: P1_y=min(Y_MAX, P1_y+speed).
  - Compute in 12 bits signed so the subtraction cannot wrap below 0 before the clamp.
- Clamp: reaching a limit sets at_limit=1 and leaves state and speed unchanged. Holding against a limit keeps P1_y at the limit every tick.
- at_limit and moving are registered alongside P1_y, so they are coherent with it.
- frame_tick asserted on consecutive cycles: each asserted cycle is a full update.
- Changes to btn_* between ticks are ignored.

Decomposition:
- Shared header/package holds:
  - the screen and sprite constants: SCREEN_H=480, SPRITE_H=50, SPRITE_W=30, SPRITE_X=500, the 1500-pixel sprite ROM depth, and the 11-bit coordinate width;
  - the IDLE/UP/DOWN state encoding.
- Y_MAX default is derived as SCREEN_H-SPRITE_H.
- One natural sub-module: p1_speed_ramp. It holds speed and acc_cnt and takes the tick, a same-direction flag and a restart flag. The FSM and clamp stay in the top module.

Test Plan:
- Reset: assert rst asynchronously mid-frame -> P1_y=215, moving=0, at_limit=0 immediately, with no clock edge needed.
- Hold btn_up for 4 ticks from 215 -> P1_y 213, 211, 209, 205 (speed 2, 2, 2, 4); moving=1.
- Hold btn_up and btn_down together, or raise freeze, for 3 ticks -> P1_y unchanged, moving=0, speed back to 0.
- Accelerate down to speed 8, then press btn_up only -> next tick P1_y decreases by exactly 2.
- Hold btn_down from 215 for 60 ticks -> P1_y never exceeds 430, settles at 430, at_limit=1. Hold up to 0 the same way -> P1_y never wraps, settles at 0.
- Hold btn_up for 1000 cycles with no frame_tick -> P1_y, moving and at_limit unchanged.
